// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher: DEPTH-entry PC/instr FIFO fed by a
// req/ready memory master, with redirect flush and in-flight drop.
module imem_prefetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     fetch_valid,
  output logic [XLEN-1:0]          fetch_instr,
  output logic [XLEN-1:0]          fetch_pc,
  input  logic                     fetch_ready,
  output logic                     mem_req,
  output logic [XLEN-1:0]          mem_addr,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] next_pc_nxt;
  logic [AW:0]     occ_nxt;
  logic            done;
  logic            push;
  logic            pop;
  logic            room;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!redirect_valid && room) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_nxt = done ? IDLE : DROP;
        end else if (done) begin
          state_nxt = room ? REQ : IDLE;
        end
      end
      DROP: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // room is judged on next occupancy so a slot freed by a pop
  // can be reserved again in the same cycle
  always_comb begin
    done = mem_req & mem_ready;
    push = done & (state == REQ) & ~redirect_valid;
    pop  = fetch_valid & fetch_ready & ~redirect_valid;
    occ_nxt = occupancy;
    if (redirect_valid) begin
      occ_nxt = '0;
    end else if (push && !pop) begin
      occ_nxt = occupancy + 1'b1;
    end else if (pop && !push) begin
      occ_nxt = occupancy - 1'b1;
    end
    room = occ_nxt < FULL;
    next_pc_nxt = next_pc;
    if (redirect_valid) begin
      next_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      next_pc_nxt = next_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      next_pc     <= RESET_PC;
      occupancy   <= '0;
      fetch_valid <= 1'b0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      mem_req     <= (state_nxt != IDLE);
      occupancy   <= occ_nxt;
      fetch_valid <= (occ_nxt != '0);
      next_pc     <= next_pc_nxt;
      // a stalled request keeps its address, even across a redirect
      if (!(mem_req && !mem_ready)) begin
        mem_addr <= next_pc_nxt;
      end
      if (redirect_valid) begin
        head <= tail;
      end else begin
        if (push) begin
          pc_mem[tail]  <= next_pc;
          ins_mem[tail] <= mem_rdata;
          tail          <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
      end
    end
  end

  assign fetch_pc    = pc_mem[head];
  assign fetch_instr = ins_mem[head];

endmodule
